// File: rtl/alu_pipe.sv
// Registered, handshaked integer ALU: single-cycle shift/logic/add ops plus an
// iterative shift-add multiply (low half or unsigned high half).
module alu_pipe #(
  parameter  int WIDTH_MAG = 5,
  localparam int WIDTH     = 1 << WIDTH_MAG
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ic,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             oc,
  output logic             oo,
  output logic             oz,
  output logic             oe
);

  typedef enum logic [3:0] {
    OP_LSL = 4'd0, OP_LSR = 4'd1, OP_CSL = 4'd2,  OP_CSR = 4'd3,  OP_ASR   = 4'd4,
    OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7,  OP_ADD = 4'd8,  OP_ADC   = 4'd9,
    OP_SUB = 4'd10, OP_MUL = 4'd11, OP_MULHU = 4'd12
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  localparam int MSB = WIDTH - 1;

  state_e               state, state_nxt;
  logic                 accept, is_mul;

  logic [2*WIDTH-1:0]   ma, acc, acc_nxt;
  logic [WIDTH-1:0]     mb;
  logic [WIDTH_MAG-1:0] cnt;
  logic                 mhi, mul_last;
  logic [WIDTH-1:0]     mul_res;
  logic                 mul_c;

  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v, res_e;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   rot;
  logic [WIDTH_MAG-1:0] sh;
  logic                 big, cin;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (opcode == OP_MUL) || (opcode == OP_MULHU);
  assign sh       = b[WIDTH_MAG-1:0];
  assign big      = |b[WIDTH-1:WIDTH_MAG];
  assign cin      = (opcode == OP_ADC) && ic;

  // NOTE: every variable driven here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    sum   = '0;
    rot   = '0;
    case (opcode)
      OP_LSL: res = big ? '0 : a << sh;
      OP_LSR: res = big ? '0 : a >> sh;
      OP_CSL: begin
        rot = {a, a} << sh;
        res = rot[2*WIDTH-1:WIDTH];
      end
      OP_CSR: begin
        rot = {a, a} >> sh;
        res = rot[WIDTH-1:0];
      end
      // if/else rather than ?: so the signed shift operand is not forced unsigned
      OP_ASR: begin
        if (big) res = {WIDTH{a[MSB]}};
        else     res = $signed(a) >>> sh;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        res   = sum[WIDTH-1:0];
        res_c = ~sum[WIDTH];
        res_v = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_MUL, OP_MULHU: ;
      default: res_e = 1'b1;
    endcase
  end

  // Shift-add step: the multiplicand walks left while the multiplier walks right.
  assign acc_nxt  = acc + (mb[0] ? ma : '0);
  assign mul_last = (state == S_MUL) && (&cnt);
  assign mul_res  = mhi ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
  assign mul_c    = !mhi && (|acc_nxt[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:  if (&cnt)             state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      cnt   <= '0;
      mhi   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && is_mul) begin
        ma  <= {{WIDTH{1'b0}}, a};
        mb  <= b;
        mhi <= (opcode == OP_MULHU);
        acc <= '0;
        cnt <= '0;
      end else if (state == S_MUL) begin
        acc <= acc_nxt;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result register: only loads when the previous result is absent or consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      oc        <= 1'b0;
      oo        <= 1'b0;
      oz        <= 1'b0;
      oe        <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      out       <= res;
      oc        <= res_c;
      oo        <= res_v;
      oz        <= !res_e && (res == '0);
      oe        <= res_e;
    end else if (mul_last) begin
      out_valid <= 1'b1;
      out       <= mul_res;
      oc        <= mul_c;
      oo        <= 1'b0;
      oz        <= (mul_res == '0);
      oe        <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH_MAG = 5 (32-bit datapath).
module tb_alu_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          ic;
  logic [3:0]    opcode;
  logic          out_valid, out_ready;
  logic [W-1:0]  out;
  logic          oc, oo, oz, oe;

  int n_tests = 0;
  int n_fail  = 0;

  alu_pipe #(.WIDTH_MAG(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ic(ic), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .oc(oc), .oo(oo), .oz(oz), .oe(oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed {out_valid, out, oc, oo, oz, oe} against the expected result.
  task automatic expect_res(input string tag, input logic [W-1:0] o,
                            input logic c, input logic v, input logic z, input logic e);
    check(tag, 64'({out_valid, out, oc, oo, oz, oe}), 64'({1'b1, o, c, v, z, e}));
  endtask

  // Present one operation for a single cycle; it must be accepted on that edge.
  task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic icv);
    opcode = op; a = av; b = bv; ic = icv; in_valid = 1'b1;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for a multiply issued on the previous edge; returns cycles to out_valid
  // and how many of them had in_ready low.
  task automatic wait_mul(output int cyc, output int lows);
    cyc = 1; lows = 0;
    while (!out_valid && cyc < 100) begin
      if (!in_ready) lows++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  int cyc, lows, stray;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ic = 1'b0; opcode = 4'd0;
    #1;
    check("rst_state", 64'({out_valid, out, oc, oo, oz, oe}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    issue("add_wrap", 4'd8, 32'hFFFF_FFFF, 32'h1, 1'b0);
    expect_res("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue("add_ovf", 4'd8, 32'h7FFF_FFFF, 32'h1, 1'b0);
    expect_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("sub_borrow", 4'd10, 32'd3, 32'd5, 1'b0);
    expect_res("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sub_ok", 4'd10, 32'd5, 32'd3, 1'b0);
    expect_res("sub_ok", 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("sub_ovf", 4'd10, 32'h8000_0000, 32'h1, 1'b0);
    expect_res("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("adc", 4'd9, 32'd1, 32'd1, 1'b1);
    expect_res("adc", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("add_no_ic", 4'd8, 32'd1, 32'd1, 1'b1);
    expect_res("add_no_ic", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    issue("lsl_big", 4'd0, 32'h1, 32'd32, 1'b0);
    expect_res("lsl_big", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("lsl", 4'd0, 32'h3, 32'd4, 1'b0);
    expect_res("lsl", 32'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("lsr", 4'd1, 32'h8000_0000, 32'd31, 1'b0);
    expect_res("lsr", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("asr_big", 4'd4, 32'h8000_0000, 32'd40, 1'b0);
    expect_res("asr_big", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("asr", 4'd4, 32'h8000_0000, 32'd4, 1'b0);
    expect_res("asr", 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("csl", 4'd2, 32'h8000_0001, 32'd33, 1'b0);
    expect_res("csl", 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("csr0", 4'd3, 32'h1, 32'd0, 1'b0);
    expect_res("csr0", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("csr1", 4'd3, 32'h1, 32'd1, 1'b0);
    expect_res("csr1", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back logic ops, one accept per cycle.
    a = 32'hF0F0_1234; b = 32'h0FF0_FF00; ic = 1'b0;
    opcode = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd6;
    expect_res("b2b_and", 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_rdy1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    opcode = 4'd7;
    expect_res("b2b_or", 32'hFFF0_FF34, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_rdy2", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_res("b2b_xor", 32'hFF00_ED34, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("idle_no_valid", 64'(out_valid), 64'd0);

    // Stalled result holds while a new op waits upstream.
    out_ready = 1'b0;
    issue("stall_add", 4'd8, 32'd10, 32'd20, 1'b0);
    opcode = 4'd10; a = 32'd50; b = 32'd8; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_res($sformatf("stall_hold%0d", i), 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("stall_rdy%0d", i), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 check("stall_release_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_res("stall_sub", 32'd42, 1'b1, 1'b0, 1'b0, 1'b0);

    issue("illegal", 4'd14, 32'd5, 32'd5, 1'b0);
    expect_res("illegal", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Multiplies; operands are scrambled after accept to prove they were latched.
    issue("mul", 4'd11, 32'h0001_0000, 32'h0001_0000, 1'b0);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; opcode = 4'd0;
    wait_mul(cyc, lows);
    check("mul_latency", 64'(cyc), 64'd33);
    check("mul_busy", 64'(lows), 64'd32);
    expect_res("mul", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    issue("mulhu", 4'd12, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_mul(cyc, lows);
    check("mulhu_latency", 64'(cyc), 64'd33);
    expect_res("mulhu", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    issue("mul_lo", 4'd11, 32'hFFFF_FFFF, 32'd3, 1'b0);
    a = 32'd0; b = 32'd0;
    wait_mul(cyc, lows);
    expect_res("mul_lo", 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b0);

    issue("mulhu_hi", 4'd12, 32'hFFFF_FFFF, 32'd3, 1'b0);
    wait_mul(cyc, lows);
    expect_res("mulhu_hi", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);

    issue("mul_small", 4'd11, 32'd7, 32'd9, 1'b0);
    wait_mul(cyc, lows);
    expect_res("mul_small", 32'd63, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply aborts it.
    issue("mul_abort", 4'd11, 32'd7, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_clear", 64'({out_valid, out, oc, oo, oz, oe}), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("abort_no_stale", 64'(stray), 64'd0);
    issue("post_add", 4'd8, 32'd2, 32'd3, 1'b0);
    expect_res("post_add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
